// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and defaults for the fc_argmax classification stage
package fc_pkg;
    localparam int FC_DATA_W      = 16;
    localparam int FC_NUM_CLASSES = 10;
    localparam int FC_IDX_W       = 4;

    typedef logic signed [FC_DATA_W-1:0] fc_score_t;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } fc_state_e;
endpackage

// File: rtl/fc_top2_update.sv
// rtl/fc_top2_update.sv - combinational top-two tracker step for one incoming score
module fc_top2_update import fc_pkg::*; #(
    parameter int DATA_W = FC_DATA_W,
    parameter int IDX_W  = FC_IDX_W
) (
    input  logic                     i_first,
    input  logic signed [DATA_W-1:0] i_best,
    input  logic        [IDX_W-1:0]  i_best_idx,
    input  logic signed [DATA_W-1:0] i_second,
    input  logic        [IDX_W-1:0]  i_second_idx,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic        [IDX_W-1:0]  i_idx,
    output logic signed [DATA_W-1:0] o_best,
    output logic        [IDX_W-1:0]  o_best_idx,
    output logic signed [DATA_W-1:0] o_second,
    output logic        [IDX_W-1:0]  o_second_idx
);
    localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Strict compares keep the earlier (lower) index on ties for both places.
    always_comb begin
        o_best       = i_best;
        o_best_idx   = i_best_idx;
        o_second     = i_second;
        o_second_idx = i_second_idx;
        if (i_first) begin
            o_best       = i_x;
            o_best_idx   = '0;
            o_second     = SCORE_MIN;
            o_second_idx = '0;
        end else if (i_x > i_best) begin
            o_second     = i_best;
            o_second_idx = i_best_idx;
            o_best       = i_x;
            o_best_idx   = i_idx;
        end else if (i_x > i_second) begin
            o_second     = i_x;
            o_second_idx = i_idx;
        end
    end
endmodule

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - per-frame argmax/top-two/margin of serial class scores with frame counter
module fc_argmax import fc_pkg::*; #(
    parameter int NUM_CLASSES = FC_NUM_CLASSES,
    parameter int DATA_W      = FC_DATA_W,
    parameter int IDX_W       = FC_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [IDX_W-1:0]  out_class,
    output logic signed [DATA_W-1:0] out_score,
    output logic        [IDX_W-1:0]  out_second,
    output logic        [DATA_W-1:0] out_margin,
    output logic                     out_error,
    output logic        [15:0]       frames_done
);
    fc_state_e                r_state;
    logic        [IDX_W-1:0]  r_cnt;
    logic signed [DATA_W-1:0] r_best;
    logic        [IDX_W-1:0]  r_best_idx;
    logic signed [DATA_W-1:0] r_second;
    logic        [IDX_W-1:0]  r_second_idx;

    logic signed [DATA_W-1:0] w_best;
    logic        [IDX_W-1:0]  w_best_idx;
    logic signed [DATA_W-1:0] w_second;
    logic        [IDX_W-1:0]  w_second_idx;
    logic                     w_accept;
    logic                     w_at_end;
    logic                     w_frame_end;

    assign in_ready    = (r_state == COLLECT);
    assign out_valid   = (r_state == RESULT);
    assign w_accept    = in_valid && in_ready;
    assign w_at_end    = (r_cnt == IDX_W'(NUM_CLASSES - 1));
    assign w_frame_end = w_accept && (w_at_end || in_last);

    fc_top2_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_update (
        .i_first      (r_cnt == '0),
        .i_best       (r_best),
        .i_best_idx   (r_best_idx),
        .i_second     (r_second),
        .i_second_idx (r_second_idx),
        .i_x          (in_data),
        .i_idx        (r_cnt),
        .o_best       (w_best),
        .o_best_idx   (w_best_idx),
        .o_second     (w_second),
        .o_second_idx (w_second_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= COLLECT;
            r_cnt        <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            r_second     <= '0;
            r_second_idx <= '0;
            out_class    <= '0;
            out_score    <= '0;
            out_second   <= '0;
            out_margin   <= '0;
            out_error    <= 1'b0;
            frames_done  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_best       <= w_best;
                        r_best_idx   <= w_best_idx;
                        r_second     <= w_second;
                        r_second_idx <= w_second_idx;
                        r_cnt        <= r_cnt + 1'b1;
                    end
                    if (w_frame_end) begin
                        r_cnt      <= '0;
                        r_state    <= RESULT;
                        out_class  <= w_best_idx;
                        out_score  <= w_best;
                        out_second <= w_second_idx;
                        // best >= second, so the true difference lies in [0, 2^DATA_W) and the wrap is exact
                        out_margin <= DATA_W'(w_best - w_second);
                        out_error  <= (in_last != w_at_end);
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        r_state     <= COLLECT;
                        frames_done <= frames_done + 16'd1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - self-checking bench for fc_argmax against a scan-based top-two model
module tb_fc_argmax;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [3:0]  out_class;
    logic signed [15:0] out_score;
    logic        [3:0]  out_second;
    logic        [15:0] out_margin;
    logic               out_error;
    logic        [15:0] frames_done;

    int vectors = 0;
    int miscompares = 0;
    int sc [10];
    int exp_frames = 0;
    logic [40:0] res;
    logic [40:0] exp_r;

    fc_argmax #(.NUM_CLASSES(10), .DATA_W(16), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_score(out_score), .out_second(out_second), .out_margin(out_margin),
        .out_error(out_error), .frames_done(frames_done)
    );

    always #5 clk = ~clk;
    assign res = {out_class, out_score, out_second, out_margin, out_error};

    // Top two by full scan: best is the lowest index holding the maximum; second is the
    // lowest index of the largest other score above the most-negative value, else index 0.
    function automatic logic [40:0] model(input int n, input bit err);
        int b, s, sv, m;
        b = 0;
        for (int i = 1; i < n; i++) if (sc[i] > sc[b]) b = i;
        s = 0;
        sv = -32768;
        for (int i = 0; i < n; i++) if (i != b && sc[i] > sv) begin sv = sc[i]; s = i; end
        m = sc[b] - sv;
        return {4'(b), 16'(sc[b]), 4'(s), 16'(m), err};
    endfunction

    task automatic send_frame(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL in_ready_beat%0d got=%b exp=1", i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = 16'(sc[i]);
            in_last  = with_last && (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_frames++;
    endtask

    task automatic fill_random(input int mode);
        logic signed [15:0] t;
        for (int i = 0; i < 10; i++) begin
            t = 16'($urandom);
            case (mode)
                0: sc[i] = int'($urandom_range(0, 6)) - 3;
                1: sc[i] = t;
                default: sc[i] = ($urandom_range(0, 1) == 0) ? -32768 : int'($urandom_range(0, 2)) - 1;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        vectors++;
        if ({in_ready, out_valid, res, frames_done} !== {1'b1, 1'b0, 41'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_state got=%b/%b/%h/%h exp=1/0/0/0", in_ready, out_valid, res, frames_done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_spec_vectors();
        sc = '{5, -3, 100, 7, 100, 2, 0, -50, 99, 1};
        out_ready = 1'b1;
        send_frame(10, 1'b1);
        exp_r = {4'd2, 16'd100, 4'd4, 16'd0, 1'b0};
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL spec_vector got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_frames++;
        vectors++;
        if ({frames_done, out_valid, in_ready} !== {16'(exp_frames), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL spec_frames_done got=%0d/%b/%b exp=%0d/0/1", frames_done, out_valid, in_ready, exp_frames);
        end
    endtask

    task automatic test_all_min();
        for (int i = 0; i < 10; i++) sc[i] = -32768;
        send_frame(10, 1'b1);
        exp_r = {4'd0, 16'h8000, 4'd0, 16'd0, 1'b0};
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL all_min got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
    endtask

    task automatic test_extreme();
        for (int i = 0; i < 10; i++) sc[i] = -32768;
        sc[3] = 32767;
        send_frame(10, 1'b1);
        exp_r = {4'd3, 16'h7FFF, 4'd0, 16'hFFFF, 1'b0};
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL extreme_margin got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
    endtask

    task automatic test_short_frame();
        fill_random(1);
        send_frame(7, 1'b1);
        exp_r = model(7, 1'b1);
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r} || out_error !== 1'b1) begin
            miscompares++;
            $display("FAIL short_frame got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
        fill_random(0);
        send_frame(10, 1'b1);
        exp_r = model(10, 1'b0);
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL after_short got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
    endtask

    task automatic test_long_no_last();
        fill_random(1);
        send_frame(10, 1'b0);
        exp_r = model(10, 1'b1);
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL no_last got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
    endtask

    task automatic test_backpressure();
        logic [15:0] fd;
        fill_random(1);
        send_frame(10, 1'b1);
        exp_r = model(10, 1'b0);
        fd = 16'(exp_frames);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, res, frames_done} !== {1'b1, 1'b0, exp_r, fd}) begin
                miscompares++;
                $display("FAIL stall_cycle%0d got=%b/%b/%h/%0d exp=1/0/%h/%0d",
                         c, out_valid, in_ready, res, frames_done, exp_r, fd);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        exp_frames++;
        vectors++;
        if ({frames_done, in_ready, out_valid} !== {16'(exp_frames), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL release got=%0d/%b/%b exp=%0d/1/0", frames_done, in_ready, out_valid, exp_frames);
        end
        @(posedge clk); #1;
        vectors++;
        if (frames_done !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL count_once got=%0d exp=%0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_reset_midframe();
        fill_random(1);
        send_frame(4, 1'b0);
        #2 reset = 1'b1;
        #1;
        exp_frames = 0;
        vectors++;
        if ({in_ready, out_valid, res, frames_done} !== {1'b1, 1'b0, 41'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL midframe_reset got=%b/%b/%h/%h exp=1/0/0/0", in_ready, out_valid, res, frames_done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        fill_random(2);
        send_frame(10, 1'b1);
        exp_r = model(10, 1'b0);
        vectors++;
        if ({out_valid, res} !== {1'b1, exp_r}) begin
            miscompares++;
            $display("FAIL after_reset got=%b/%h exp=1/%h", out_valid, res, exp_r);
        end
        take();
        vectors++;
        if (frames_done !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL after_reset_count got=%0d exp=%0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_random();
        int r, n, stall;
        bit lst;
        for (int f = 0; f < 40; f++) begin
            fill_random(int'($urandom_range(0, 2)));
            r = int'($urandom_range(0, 9));
            if (r < 6) begin n = 10; lst = 1'b1; end
            else if (r < 8) begin n = int'($urandom_range(1, 9)); lst = 1'b1; end
            else begin n = 10; lst = 1'b0; end
            send_frame(n, lst);
            exp_r = model(n, !(n == 10 && lst));
            stall = int'($urandom_range(0, 3));
            for (int c = 0; c < stall; c++) begin @(posedge clk); #1; end
            vectors++;
            if ({out_valid, res} !== {1'b1, exp_r}) begin
                miscompares++;
                $display("FAIL random_frame%0d got=%b/%h exp=1/%h", f, out_valid, res, exp_r);
            end
            take();
            vectors++;
            if (frames_done !== 16'(exp_frames)) begin
                miscompares++;
                $display("FAIL random_count%0d got=%0d exp=%0d", f, frames_done, exp_frames);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_all_min();
        test_extreme();
        test_short_frame();
        test_long_no_last();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage directly downstream of the second fully connected layer (84→10). Consumes the 10 signed 16-bit class scores of one image as a serial valid/ready stream, tracks the top two scores, and presents one result per frame: winning class, its score, the runner-up class and the top1−top2 margin. Frame-length errors are flagged, and a completed-frame counter is maintained.

## Interface
- NUM_CLASSES, 10, scores per frame; must be ≥2
- DATA_W, 16, score width, signed two's complement
- IDX_W, 4, class index width; must satisfy 2^IDX_W ≥ NUM_CLASSES
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- in_valid  in  1  score beat valid
- in_data  in  DATA_W  signed score, class order 0..NUM_CLASSES-1
- in_last  in  1  marks final beat of frame
- in_ready  out  1  block accepts a beat
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- out_class  out  IDX_W  index of maximum score
- out_score  out  DATA_W  maximum score
- out_second  out  IDX_W  index of second-highest score
- out_margin  out  DATA_W  unsigned out_score − second score
- out_error  out  1  frame length mismatch on this result
- frames_done  out  16  results consumed, wraps at 2^16

## Operation
- Two states: COLLECT (in_ready=1, out_valid=0) and RESULT (in_ready=0, out_valid=1).
- Beat accepted when in_valid && in_ready; beat counter cnt (IDX_W bits) gives its class index.
- First beat (cnt=0): best=in_data, best_idx=0; second=most negative value (0x8000 for DATA_W=16), second_idx=0.
- Later beats, compared as signed values: if x > best, then second←best, second_idx←best_idx, best←x, best_idx←cnt. Otherwise, if x > second, then second←x, second_idx←cnt. Strict comparisons, so on ties the lower index wins for both places.
- Frame ends on the accepted beat where cnt=NUM_CLASSES−1 or in_last=1, whichever comes first.
- Error is set when in_last is asserted with cnt≠NUM_CLASSES−1, or when in_last is deasserted at cnt=NUM_CLASSES−1. In both cases the result is still produced from the beats received.
- Margin is best−second, computed at DATA_W+1 bits. The result is always ≥0 and fits DATA_W bits unsigned, so no saturation is needed.
- On frame end: register the outputs, go to RESULT, clear cnt.
- RESULT→COLLECT when out_ready=1. In the same edge, frames_done increments. There is no bypass: in_ready rises the cycle after the handshake.
- Output registers hold stable throughout RESULT, regardless of in_valid activity.

## Timing
- Reset values: in_ready=1 (COLLECT), out_valid=0, out_class=0, out_score=0, out_second=0, out_margin=0, out_error=0, frames_done=0; internal cnt/best/second cleared.
- Throughput in COLLECT: one beat per cycle.
- Latency: out_valid is high the cycle after the final beat is accepted.
- Minimum frame period: NUM_CLASSES+1 cycles when out_ready is held at 1.
- Reset mid-frame or mid-RESULT: takes effect immediately and asynchronously. The partial frame or pending result is discarded, and frames_done is not incremented.
- in_valid/in_data may change freely while in_ready=0; they are ignored.
- A frame is never counted as done without the out_valid&&out_ready handshake.

## Structure
- Shared package fc_pkg:
  - FC_DATA_W=16, FC_NUM_CLASSES=10
  - typedef fc_score_t (logic signed [FC_DATA_W-1:0])
  - typedef fc_state_e {COLLECT, RESULT}
- Sub-module fc_top2_update: purely combinational. Inputs: current best/second (values and indices), incoming score and index, first-beat flag. Outputs: next best/second. Keeps the compare logic unit-testable in isolation.
- The parent holds the state machine, counters, output registers and error logic.

## Test plan
- Scores 5,−3,100,7,100,2,0,−50,99,1 (in_last on beat 9), out_ready=1:
  - class=2, score=100, second=4, margin=0, error=0
  - frames_done=1 two cycles after the last beat
- All ten scores = 0x8000:
  - class=0, second=0, margin=0, error=0
- Scores 32767 at index 3 and −32768 elsewhere:
  - class=3, second=0, margin=65535 (0xFFFF), error=0
- in_last on beat 6:
  - result valid the next cycle from 7 beats, error=1
  - a following correct frame reports error=0
- Ten beats with no in_last:
  - frame ends on beat 9, error=1
- out_ready held 0 for 20 cycles while in_valid=1:
  - outputs stable, in_ready=0, no beats accepted
- Then out_ready=1 for one cycle:
  - frames_done increments once
  - in_ready=1 on the next cycle
- Reset asserted after 4 beats:
  - outputs return to reset values immediately
  - a subsequent full frame produces a correct result
